bus_mux_reg: RTL and testbench

- Parametrised, registered successor to the 32:1 datapath bus multiplexer.
- Selects one of NSRC source words from a one-hot output-enable vector (the RnOut/PCout/MDRout style strobes) and drives the shared datapath bus from a register.
- Adds priority resolution, a bus keeper, a conflict detector with a saturating counter, and a hold (stall) input.
- Sits between the register file/special registers and every bus consumer in the CPU datapath.

---
 rtl/bus_mux_reg.sv | 94 +++++++++
 tb/tb_bus_mux_reg.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_reg.sv
// rtl/bus_mux_reg.sv - registered priority bus multiplexer with keeper and conflict detection
// Optional feature macro: BUS_MUX_PARITY_EN (adds registered even-parity output bus_par).
// bus_valid doubles as the IDLE(0)/DRIVE(1) state; no separate state register is kept.
module bus_mux_reg #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  parameter int SELW  = $clog2(NSRC),
  parameter int CNTW  = 8
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_out,
  input  logic                  hold,
  input  logic                  conflict_clr,
  output logic [WIDTH-1:0]      bus_q,
  output logic                  bus_valid,
  output logic [SELW-1:0]       bus_src,
  output logic                  conflict,
  output logic [CNTW-1:0]       conflict_cnt
`ifdef BUS_MUX_PARITY_EN
  ,
  output logic                  bus_par
`endif
);

  logic [SELW-1:0]  winIdx;
  logic [WIDTH-1:0] winData;
  logic             anyHot;
  logic             multiHot;

  // Priority encoder: scanning downward lets the lowest set index overwrite the rest.
  always_comb begin
    winIdx  = '0;
    winData = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_out[i]) begin
        winIdx  = SELW'(i);
        winData = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Clearing the lowest set bit leaves something behind only when two or more bits are set.
  assign anyHot   = |src_out;
  assign multiHot = |(src_out & (src_out - NSRC'(1)));

  // Bus register with keeper: an all-zero strobe vector keeps the last word and source index.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bus_q     <= '0;
      bus_src   <= '0;
      bus_valid <= 1'b0;
    end else if (!hold) begin
      bus_valid <= anyHot;
      if (anyHot) begin
        bus_q   <= winData;
        bus_src <= winIdx;
      end
    end
  end

  // Conflict tracking: sticky flag plus saturating count; a clear beats a same-cycle conflict.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else if (!hold) begin
      if (conflict_clr) begin
        conflict     <= 1'b0;
        conflict_cnt <= '0;
      end else if (multiHot) begin
        conflict <= 1'b1;
        if (conflict_cnt != {CNTW{1'b1}}) begin
          conflict_cnt <= conflict_cnt + CNTW'(1);
        end
      end
    end
  end

`ifdef BUS_MUX_PARITY_EN
  // Parity follows bus_q exactly: loaded from the winning word, frozen by hold and the keeper.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bus_par <= 1'b0;
    end else if (!hold && anyHot) begin
      bus_par <= ^winData;
    end
  end
`else
  // Parity disabled: no bus_par port and no parity register in this build.
`endif

endmodule

// File: tb/tb_bus_mux_reg.sv
// tb/tb_bus_mux_reg.sv - table-driven scoreboard bench for bus_mux_reg
module tb_bus_mux_reg;
  localparam int WIDTH = 32;
  localparam int NSRC  = 24;
  localparam int SELW  = 5;
  localparam int CNTW  = 2;

  typedef struct {
    logic [NSRC-1:0]  srcOut;
    logic             hold;
    logic             cclr;
    int               idxA;
    logic [WIDTH-1:0] valA;
    int               idxB;
    logic [WIDTH-1:0] valB;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic [SELW-1:0]  src;
    logic             conf;
    logic [CNTW-1:0]  cnt;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  clrN;
  logic [NSRC*WIDTH-1:0] srcData;
  logic [NSRC-1:0]       srcOut;
  logic                  hold;
  logic                  conflictClr;
  logic [WIDTH-1:0]      busQ;
  logic                  busValid;
  logic [SELW-1:0]       busSrc;
  logic                  conflict;
  logic [CNTW-1:0]       conflictCnt;
`ifdef BUS_MUX_PARITY_EN
  logic                  busPar;
`endif

  int nChecks = 0;
  int nFails  = 0;
  vec_t vecs[$];
  vec_t expQ[$];

  bus_mux_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .CNTW(CNTW)) dut (
    .clk          (clk),
    .clr_n        (clrN),
    .src_data     (srcData),
    .src_out      (srcOut),
    .hold         (hold),
    .conflict_clr (conflictClr),
    .bus_q        (busQ),
    .bus_valid    (busValid),
    .bus_src      (busSrc),
    .conflict     (conflict),
    .conflict_cnt (conflictCnt)
`ifdef BUS_MUX_PARITY_EN
    ,
    .bus_par      (busPar)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [NSRC-1:0] so, input logic h, input logic cc,
                              input int ia, input logic [WIDTH-1:0] va,
                              input int ib, input logic [WIDTH-1:0] vb,
                              input logic [WIDTH-1:0] q, input logic v, input int s,
                              input logic cf, input int cn);
    vec_t r;
    r.srcOut = so; r.hold = h; r.cclr = cc;
    r.idxA = ia; r.valA = va; r.idxB = ib; r.valB = vb;
    r.q = q; r.valid = v; r.src = SELW'(s); r.conf = cf; r.cnt = CNTW'(cn);
    return r;
  endfunction

  task automatic loadBaseData();
    for (int i = 0; i < NSRC; i++) srcData[i*WIDTH +: WIDTH] = 32'hA500_0000 | i;
  endtask

  task automatic applyVec(input vec_t v);
    loadBaseData();
    if (v.idxA >= 0) srcData[v.idxA*WIDTH +: WIDTH] = v.valA;
    if (v.idxB >= 0) srcData[v.idxB*WIDTH +: WIDTH] = v.valB;
    srcOut      = v.srcOut;
    hold        = v.hold;
    conflictClr = v.cclr;
    expQ.push_back(v);
  endtask

  task automatic checkOut(input string tag);
    vec_t e;
    if (expQ.size() == 0) begin
      chk({tag, " scoreboard empty"}, 64'd1, 64'd0);
      return;
    end
    e = expQ.pop_front();
    chk({tag, " bus_q"},        64'(busQ),        64'(e.q));
    chk({tag, " bus_valid"},    64'(busValid),    64'(e.valid));
    chk({tag, " bus_src"},      64'(busSrc),      64'(e.src));
    chk({tag, " conflict"},     64'(conflict),    64'(e.conf));
    chk({tag, " conflict_cnt"}, 64'(conflictCnt), 64'(e.cnt));
`ifdef BUS_MUX_PARITY_EN
    chk({tag, " bus_par"},      64'(busPar),      64'(^e.q));
`endif
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, " bus_q"},        64'(busQ),        64'd0);
    chk({tag, " bus_valid"},    64'(busValid),    64'd0);
    chk({tag, " bus_src"},      64'(busSrc),      64'd0);
    chk({tag, " conflict"},     64'(conflict),    64'd0);
    chk({tag, " conflict_cnt"}, 64'(conflictCnt), 64'd0);
`ifdef BUS_MUX_PARITY_EN
    chk({tag, " bus_par"},      64'(busPar),      64'd0);
`endif
  endtask

  initial begin
    clrN = 1'b0; hold = 1'b0; conflictClr = 1'b0; srcOut = '0;
    loadBaseData();

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1 checkAllZero("por");
    #3 clrN = 1'b1;

    // Load with a conflict, then assert reset mid-cycle and check outputs before any edge
    srcOut = 24'h000018;
    @(posedge clk); #1;
    chk("preload bus_q", 64'(busQ), 64'h0000_0000_A500_0003);
    chk("preload conflict", 64'(conflict), 64'd1);
    srcOut = 24'h000008;
    #3 clrN = 1'b0;
    #1 checkAllZero("async reset");
    @(posedge clk); #1;
    checkAllZero("reset held over edge");
    #2 clrN = 1'b1;

    // Vector table: srcOut, hold, clr, overrides, expected q/valid/src/conflict/cnt
    vecs.push_back(mk(24'h000020, 0, 0,  5, 32'hDEADBEEF, -1, 0, 32'hDEADBEEF, 1,  5, 0, 0));
    vecs.push_back(mk(24'h000000, 0, 0, -1, 0, -1, 0,          32'hDEADBEEF, 0,  5, 0, 0));
    vecs.push_back(mk(24'h000000, 0, 0, -1, 0, -1, 0,          32'hDEADBEEF, 0,  5, 0, 0));
    vecs.push_back(mk(24'h000000, 0, 0, -1, 0, -1, 0,          32'hDEADBEEF, 0,  5, 0, 0));
    vecs.push_back(mk(24'h000208, 0, 0,  3, 32'h11, 9, 32'h99, 32'h00000011, 1,  3, 1, 1));
    vecs.push_back(mk(24'h000208, 0, 0,  3, 32'h11, 9, 32'h99, 32'h00000011, 1,  3, 1, 2));
    vecs.push_back(mk(24'h000208, 0, 0,  3, 32'h11, 9, 32'h99, 32'h00000011, 1,  3, 1, 3));
    vecs.push_back(mk(24'h000208, 0, 0,  3, 32'h11, 9, 32'h99, 32'h00000011, 1,  3, 1, 3));
    vecs.push_back(mk(24'h000208, 0, 0,  3, 32'h11, 9, 32'h99, 32'h00000011, 1,  3, 1, 3));
    vecs.push_back(mk(24'h000208, 0, 0,  3, 32'h11, 9, 32'h99, 32'h00000011, 1,  3, 1, 3));
    vecs.push_back(mk(24'h000208, 0, 1,  3, 32'h11, 9, 32'h99, 32'h00000011, 1,  3, 0, 0));
    vecs.push_back(mk(24'h000208, 0, 0,  3, 32'h11, 9, 32'h99, 32'h00000011, 1,  3, 1, 1));
    vecs.push_back(mk(24'h000001, 1, 1,  0, 32'hFFFF0000, -1, 0, 32'h00000011, 1, 3, 1, 1));
    vecs.push_back(mk(24'h000001, 0, 0,  0, 32'hFFFF0000, -1, 0, 32'hFFFF0000, 1, 0, 1, 1));
    vecs.push_back(mk(24'h000000, 0, 0, -1, 0, -1, 0,          32'hFFFF0000, 0,  0, 1, 1));
    vecs.push_back(mk(24'h800000, 1, 0, 23, 32'h12345678, -1, 0, 32'hFFFF0000, 0, 0, 1, 1));
    vecs.push_back(mk(24'h800000, 0, 0, 23, 32'h12345678, -1, 0, 32'h12345678, 1, 23, 1, 1));
    vecs.push_back(mk(24'h000000, 0, 1, -1, 0, -1, 0,          32'h12345678, 0, 23, 0, 0));
    vecs.push_back(mk(24'h000080, 0, 1, -1, 0, -1, 0,          32'hA5000007, 1,  7, 0, 0));
    vecs.push_back(mk(24'hFFFFFF, 0, 0, -1, 0, -1, 0,          32'hA5000000, 1,  0, 1, 1));
    vecs.push_back(mk(24'h000002, 0, 0,  1, 32'h00000007, -1, 0, 32'h00000007, 1, 1, 1, 1));
    vecs.push_back(mk(24'h000004, 0, 0,  2, 32'h00000003, -1, 0, 32'h00000003, 1, 2, 1, 1));

    foreach (vecs[k]) begin
      applyVec(vecs[k]);
      @(posedge clk); #1;
      checkOut($sformatf("vec%0d", k));
    end

    // Reset overrides hold, asserted mid-cycle
    hold = 1'b1; srcOut = 24'h000001; conflictClr = 1'b0;
    @(posedge clk); #1;
    chk("hold keeps conflict", 64'(conflict), 64'd1);
    #2 clrN = 1'b0;
    #1 checkAllZero("reset during hold");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
